// File: rtl/dual_issue_sequencer_if.sv
// Fetch-packet, hazard-verdict and issue-slot bundle between the fetch stage,
// the dual-issue sequencer and the decode/execute slots.
interface dual_issue_sequencer_if #(
    parameter int IW    = 32,
    parameter int AW    = 32,
    parameter int CNT_W = 16
);
    logic             pkt_valid;
    logic [IW-1:0]    pkt_inst1;
    logic [IW-1:0]    pkt_inst2;
    logic [AW-1:0]    pkt_pc;
    logic             dep_stall;
    logic             flush_inst2;
    logic             back_stall;
    logic             redirect;
    logic             pkt_ready;
    logic             s0_valid;
    logic [IW-1:0]    s0_inst;
    logic [AW-1:0]    s0_pc;
    logic             s1_valid;
    logic [IW-1:0]    s1_inst;
    logic [AW-1:0]    s1_pc;
    logic [CNT_W-1:0] pair_cnt;
    logic [CNT_W-1:0] split_cnt;
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        output pkt_valid, pkt_inst1, pkt_inst2, pkt_pc,
               dep_stall, flush_inst2, back_stall, redirect,
        input  pkt_ready, s0_valid, s0_inst, s0_pc, s1_valid, s1_inst, s1_pc,
               pair_cnt, split_cnt, drop_cnt
    );

    modport slave (
        input  pkt_valid, pkt_inst1, pkt_inst2, pkt_pc,
               dep_stall, flush_inst2, back_stall, redirect,
        output pkt_ready, s0_valid, s0_inst, s0_pc, s1_valid, s1_inst, s1_pc,
               pair_cnt, split_cnt, drop_cnt
    );
endinterface

// File: rtl/dual_issue_sequencer.sv
// Dual-issue sequencer: issues a fetch packet as a pair, splits it over two
// cycles on an intra-packet hazard, or drops inst2 on a slot-0 branch flush.
module dual_issue_sequencer #(
    parameter int IW    = 32,
    parameter int AW    = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    dual_issue_sequencer_if.slave bus
);
    typedef enum logic {PAIR, SPLIT} state_e;

    state_e           state_q;
    logic             s0_valid_q, s1_valid_q;
    logic [IW-1:0]    s0_inst_q, s1_inst_q, hold_inst_q;
    logic [AW-1:0]    s0_pc_q, s1_pc_q, hold_pc_q;
    logic [CNT_W-1:0] pair_cnt_q, split_cnt_q, drop_cnt_q;
    logic [CNT_W-1:0] pair_cnt_d, split_cnt_d, drop_cnt_d;
    logic [AW-1:0]    pc_plus4;

    // Saturating increments; counters stick at all-ones.
    assign pair_cnt_d  = (&pair_cnt_q)  ? pair_cnt_q  : pair_cnt_q  + 1'b1;
    assign split_cnt_d = (&split_cnt_q) ? split_cnt_q : split_cnt_q + 1'b1;
    assign drop_cnt_d  = (&drop_cnt_q)  ? drop_cnt_q  : drop_cnt_q  + 1'b1;
    assign pc_plus4    = bus.pkt_pc + AW'(4);

    assign bus.pkt_ready = !rst_i && !bus.redirect && !bus.back_stall
                         && (state_q == PAIR) && bus.pkt_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= PAIR;
            s0_valid_q  <= 1'b0;
            s0_inst_q   <= '0;
            s0_pc_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_inst_q   <= '0;
            s1_pc_q     <= '0;
            hold_inst_q <= '0;
            hold_pc_q   <= '0;
            pair_cnt_q  <= '0;
            split_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else if (bus.redirect) begin
            state_q     <= PAIR;
            s0_valid_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            hold_inst_q <= '0;
            hold_pc_q   <= '0;
        end else if (!bus.back_stall) begin
            unique case (state_q)
                PAIR: begin
                    if (!bus.pkt_valid) begin
                        s0_valid_q <= 1'b0;
                        s1_valid_q <= 1'b0;
                    end else begin
                        s0_valid_q <= 1'b1;
                        s0_inst_q  <= bus.pkt_inst1;
                        s0_pc_q    <= bus.pkt_pc;
                        // Flush wins over the hazard: a dropped inst2 never needs splitting.
                        if (bus.flush_inst2) begin
                            s1_valid_q <= 1'b0;
                            drop_cnt_q <= drop_cnt_d;
                        end else if (bus.dep_stall) begin
                            s1_valid_q  <= 1'b0;
                            hold_inst_q <= bus.pkt_inst2;
                            hold_pc_q   <= pc_plus4;
                            split_cnt_q <= split_cnt_d;
                            state_q     <= SPLIT;
                        end else begin
                            s1_valid_q <= 1'b1;
                            s1_inst_q  <= bus.pkt_inst2;
                            s1_pc_q    <= pc_plus4;
                            pair_cnt_q <= pair_cnt_d;
                        end
                    end
                end
                SPLIT: begin
                    s0_valid_q <= 1'b1;
                    s0_inst_q  <= hold_inst_q;
                    s0_pc_q    <= hold_pc_q;
                    s1_valid_q <= 1'b0;
                    state_q    <= PAIR;
                end
                default: state_q <= PAIR;
            endcase
        end
    end

    assign bus.s0_valid  = s0_valid_q;
    assign bus.s0_inst   = s0_inst_q;
    assign bus.s0_pc     = s0_pc_q;
    assign bus.s1_valid  = s1_valid_q;
    assign bus.s1_inst   = s1_inst_q;
    assign bus.s1_pc     = s1_pc_q;
    assign bus.pair_cnt  = pair_cnt_q;
    assign bus.split_cnt = split_cnt_q;
    assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: doc/dual_issue_sequencer.md
Name: dual_issue_sequencer

Overview:
Issue sequencer between the fetch-packet register and the decode/execute slots of the dual-issue pipeline. Each cycle it takes a two-instruction packet plus the intra-packet dependency and branch-flush verdicts. It issues both instructions together, or issues them serially over two cycles. It also drops slot 1 when a branch in slot 0 requires it. It owns the fetch-advance handshake and keeps issue statistics.

Parameters:
IW, 32, instruction width
AW, 32, PC width
CNT_W, 16, width of each statistics counter

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
pkt_valid  input  1  fetch packet present
pkt_inst1  input  IW  packet slot-1 instruction (older)
pkt_inst2  input  IW  packet slot-2 instruction (younger)
pkt_pc  input  AW  PC of pkt_inst1; pkt_inst2 is at pkt_pc+4
dep_stall  input  1  intra-packet RAW/WAR hazard: inst2 must not issue with inst1
flush_inst2  input  1  discard inst2 (slot-1 branch predicted taken, or branch pair)
back_stall  input  1  downstream freeze (load-use etc.)
redirect  input  1  mispredict or jump redirect: kill all in-flight issue state
pkt_ready  output  1  packet consumed this cycle (fetch may advance)
s0_valid  output  1  issue slot 0 valid
s0_inst  output  IW  issue slot 0 instruction
s0_pc  output  AW  issue slot 0 PC
s1_valid  output  1  issue slot 1 valid
s1_inst  output  IW  issue slot 1 instruction
s1_pc  output  AW  issue slot 1 PC
pair_cnt  output  CNT_W  cycles that issued two instructions
split_cnt  output  CNT_W  packets that were split over two cycles
drop_cnt  output  CNT_W  inst2 discards due to flush_inst2

Behaviour:
- States: PAIR and SPLIT. Holding register hold_inst/hold_pc stores the deferred inst2.
- Slot outputs are registered. An issue decision made in cycle N appears on s0/s1 in cycle N+1.
- Reset (sync, rst=1 at posedge): state=PAIR. All s*_valid=0, s*_inst=0, s*_pc=0. Hold register=0. All counters=0. Reset mid-split abandons the held instruction.
- Priority each cycle: rst > redirect > back_stall > normal.
- redirect: next state=PAIR. Both slot valids cleared next cycle. Hold register invalidated. pkt_ready=0. Counters unchanged.
- back_stall (no redirect): all registers hold their values. pkt_ready=0.
- PAIR, pkt_valid=0: slot valids cleared (bubble). pkt_ready=0.
- PAIR, pkt_valid=1, flush_inst2=1: s0 loads inst1/pkt_pc. s1_valid=0. pkt_ready=1. drop_cnt++. Stay PAIR. flush_inst2 overrides dep_stall; no split occurs.
- PAIR, pkt_valid=1, dep_stall=1, flush_inst2=0: s0 loads inst1/pkt_pc. s1_valid=0. inst2 and pkt_pc+4 are latched into the hold register. pkt_ready=1. Next state=SPLIT. split_cnt++.
- PAIR, pkt_valid=1, neither: s0 loads inst1, s1 loads inst2/pkt_pc+4, both valid. pkt_ready=1. pair_cnt++.
- SPLIT (no redirect/stall): s0 loads hold_inst/hold_pc. s1_valid=0. pkt_ready=0 regardless of pkt_valid. Next state=PAIR.
- pkt_ready is combinational from state and inputs. It is never 1 while back_stall, redirect or rst is 1, or when in SPLIT.
- Counters saturate at all-ones and do not wrap. They freeze under back_stall.
- PC arithmetic is modulo 2^AW: pkt_pc+4 wraps silently.

Test Plan:
1. rst=1 for 2 cycles, then pkt_valid=1, inst1=0x11, inst2=0x22, pc=0x100, no hazards → next cycle s0=(0x11,0x100), s1=(0x22,0x104), both valid; pkt_ready=1; pair_cnt=1.
2. Same packet with dep_stall=1 → cycle N+1: s0=0x11 only, state SPLIT, pkt_ready=0 in N+1. Cycle N+2: s0=(0x22,0x104), s1_valid=0. Next packet accepted in N+2; split_cnt=1.
3. dep_stall=1 and flush_inst2=1 together → s0=0x11, s1_valid=0, no SPLIT, pkt_ready=1, drop_cnt=1, split_cnt unchanged.
4. back_stall=1 in SPLIT for 3 cycles → outputs and state frozen, pkt_ready=0. Release → held 0x22 issues exactly once.
5. redirect=1 while in SPLIT → next cycle both valids 0, state PAIR, held inst never issues. The next packet pairs normally.
6. Force pair_cnt to all-ones (CNT_W=4 build, 16 paired packets) → pair_cnt stays 0xF; pc=0xFFFFFFFC gives s1_pc=0x0.
